// File: rtl/exu_agu.sv
// Address generation unit: computes effective address, store lanes and masks,
// issues one memory command and returns a single writeback per request.
module exu_agu #(
    parameter int XLEN    = 32,
    parameter int PC_SIZE = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                agu_i_valid,
    output logic                agu_o_ready,
    input  logic                agu_i_load,
    input  logic                agu_i_store,
    input  logic                agu_i_usign,
    input  logic [1:0]          agu_i_size,
    input  logic [XLEN-1:0]     agu_i_rs1,
    input  logic [XLEN-1:0]     agu_i_imm,
    input  logic [XLEN-1:0]     agu_i_rs2,
    input  logic [4:0]          agu_i_rdidx,
    output logic                memtop_o_cmd_enable,
    output logic                memtop_o_cmd_read,
    output logic                memtop_o_cmd_write,
    output logic                memtop_o_cmd_usign,
    output logic [1:0]          memtop_o_cmd_size,
    output logic [PC_SIZE-1:0]  memtop_o_cmd_addr,
    output logic [XLEN-1:0]     memtop_o_cmd_wdata,
    output logic [XLEN/8-1:0]   memtop_o_cmd_wmask,
    output logic                memtop_o_cmd_misalgn,
    input  logic                memtop_i_ready,
    input  logic [XLEN-1:0]     memtop_i_wbck_wdata,
    input  logic                memtop_i_wbck_err,
    output logic                agu_o_wbck_valid,
    input  logic                agu_i_wbck_ready,
    output logic                agu_o_wbck_wen,
    output logic [4:0]          agu_o_wbck_rdidx,
    output logic [XLEN-1:0]     agu_o_wbck_wdata,
    output logic                agu_o_wbck_err
);

    localparam int MW = XLEN / 8;
    localparam logic [MW-1:0] M_B = MW'(1);
    localparam logic [MW-1:0] M_H = MW'(3);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WBCK
    } state_e;

    state_e state_q, state_d;

    logic               load_q, load_d;
    logic               store_q, store_d;
    logic               usign_q, usign_d;
    logic               misalgn_q, misalgn_d;
    logic               err_q, err_d;
    logic [1:0]         size_q, size_d;
    logic [4:0]         rdidx_q, rdidx_d;
    logic [PC_SIZE-1:0] addr_q, addr_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;
    logic [MW-1:0]      wmask_q, wmask_d;
    logic [XLEN-1:0]    rdata_q, rdata_d;

    logic [PC_SIZE-1:0] addr_c;
    logic               misalgn_c;
    logic [XLEN-1:0]    wdata_c;
    logic [MW-1:0]      wmask_c;

    logic in_cmd;
    logic in_wb;

    assign addr_c = agu_i_rs1[PC_SIZE-1:0] + agu_i_imm[PC_SIZE-1:0];

    // Alignment check and store lane/mask formation for the incoming request
    always_comb begin
        misalgn_c = 1'b0;
        wdata_c   = agu_i_rs2;
        wmask_c   = '1;
        unique case (agu_i_size)
            2'b00: begin
                wdata_c = {MW{agu_i_rs2[7:0]}};
                wmask_c = M_B << addr_c[1:0];
            end
            2'b01: begin
                misalgn_c = addr_c[0];
                wdata_c   = {(XLEN/16){agu_i_rs2[15:0]}};
                wmask_c   = M_H << addr_c[1:0];
            end
            2'b10: begin
                misalgn_c = |addr_c[1:0];
            end
            default: begin
                misalgn_c = 1'b1;
            end
        endcase
        if (agu_i_load == agu_i_store) begin
            misalgn_c = 1'b1;
        end
    end

    // Next-state and request/response capture
    always_comb begin
        state_d   = state_q;
        load_d    = load_q;
        store_d   = store_q;
        usign_d   = usign_q;
        misalgn_d = misalgn_q;
        err_d     = err_q;
        size_d    = size_q;
        rdidx_d   = rdidx_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        rdata_d   = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (agu_i_valid) begin
                    load_d    = agu_i_load;
                    store_d   = agu_i_store;
                    usign_d   = agu_i_usign;
                    size_d    = agu_i_size;
                    rdidx_d   = agu_i_rdidx;
                    addr_d    = addr_c;
                    misalgn_d = misalgn_c;
                    err_d     = misalgn_c;
                    rdata_d   = '0;
                    wdata_d   = (agu_i_store && !misalgn_c) ? wdata_c : '0;
                    wmask_d   = (agu_i_store && !misalgn_c) ? wmask_c : '0;
                    state_d   = misalgn_c ? WBCK : CMD;
                end
            end
            CMD: begin
                if (memtop_i_ready) begin
                    rdata_d = memtop_i_wbck_wdata;
                    err_d   = memtop_i_wbck_err;
                    state_d = WBCK;
                end
            end
            WBCK: begin
                if (agu_i_wbck_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            load_q    <= 1'b0;
            store_q   <= 1'b0;
            usign_q   <= 1'b0;
            misalgn_q <= 1'b0;
            err_q     <= 1'b0;
            size_q    <= '0;
            rdidx_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            load_q    <= load_d;
            store_q   <= store_d;
            usign_q   <= usign_d;
            misalgn_q <= misalgn_d;
            err_q     <= err_d;
            size_q    <= size_d;
            rdidx_q   <= rdidx_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            rdata_q   <= rdata_d;
        end
    end

    assign in_cmd = (state_q == CMD);
    assign in_wb  = (state_q == WBCK);

    assign agu_o_ready = (state_q == IDLE);

    assign memtop_o_cmd_enable  = in_cmd;
    assign memtop_o_cmd_read    = in_cmd & load_q;
    assign memtop_o_cmd_write   = in_cmd & store_q;
    assign memtop_o_cmd_usign   = in_cmd & usign_q;
    assign memtop_o_cmd_misalgn = in_cmd & misalgn_q;
    assign memtop_o_cmd_size    = in_cmd ? size_q : '0;
    assign memtop_o_cmd_addr    = in_cmd ? addr_q : '0;
    assign memtop_o_cmd_wdata   = in_cmd ? wdata_q : '0;
    assign memtop_o_cmd_wmask   = in_cmd ? wmask_q : '0;

    assign agu_o_wbck_valid = in_wb;
    assign agu_o_wbck_wen   = in_wb & load_q & ~err_q;
    assign agu_o_wbck_err   = in_wb & err_q;
    assign agu_o_wbck_rdidx = in_wb ? rdidx_q : '0;
    assign agu_o_wbck_wdata = (in_wb && load_q) ? rdata_q : '0;

endmodule

// File: doc/exu_agu.md
EXU_AGU -- requirements
Module: exu_agu

Interface
REQ-001 SHALL have parameters (name, default, meaning):
  XLEN, 32, data width.
  PC_SIZE, 32, address width.
REQ-002 SHALL have ports (name  direction  width  meaning):
  clk  in  1  single clock; all state on rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  agu_i_valid  in  1  load/store request valid.
  agu_o_ready  out  1  request accepted when valid&ready.
  agu_i_load  in  1  load op.
  agu_i_store  in  1  store op.
  agu_i_usign  in  1  unsigned load.
  agu_i_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
  agu_i_rs1  in  XLEN  base operand.
  agu_i_imm  in  XLEN  sign-extended offset.
  agu_i_rs2  in  XLEN  store data.
  agu_i_rdidx  in  5  load destination register.
  memtop_o_cmd_enable/read/write/usign  out  1 each  command to memory stage.
  memtop_o_cmd_size  out  2  access size.
  memtop_o_cmd_addr  out  PC_SIZE  effective address.
  memtop_o_cmd_wdata  out  XLEN  lane-replicated store data.
  memtop_o_cmd_wmask  out  XLEN/8  byte enables.
  memtop_o_cmd_misalgn  out  1  misalignment flag (always 0 when enable=1).
  memtop_i_ready  in  1  memory stage completes this cycle.
  memtop_i_wbck_wdata  in  XLEN  load result.
  memtop_i_wbck_err  in  1  memory access error.
  agu_o_wbck_valid  out  1  writeback valid.
  agu_i_wbck_ready  in  1  writeback consumed.
  agu_o_wbck_wen  out  1  register write enable.
  agu_o_wbck_rdidx  out  5  destination register.
  agu_o_wbck_wdata  out  XLEN  writeback data.
  agu_o_wbck_err  out  1  misaligned/illegal/memory error.

Function
REQ-003 SHALL implement FSM IDLE, CMD, WBCK; agu_o_ready = (state==IDLE).
REQ-004 In IDLE on valid&ready SHALL register op, usign, size, rdidx, addr = rs1+imm (mod 2^PC_SIZE, carry dropped), wdata, wmask, misalgn.
REQ-005 Accepted request with neither load nor store, or with both, SHALL be treated as illegal (misalgn=1).
REQ-006 misalgn SHALL be 1 for size 11; size 01 with addr[0]=1; size 10 with addr[1:0]!=0.
REQ-007 Store wmask SHALL be 0001<<addr[1:0] (byte), 0011<<addr[1:0] (half), 1111 (word); load wmask SHALL be 0000.
REQ-008 Store wdata SHALL be {4{rs2[7:0]}} byte, {2{rs2[15:0]}} half, rs2 word.
REQ-009 Accept with misalgn=0 SHALL go to CMD; with misalgn=1 SHALL go directly to WBCK with err=1, wdata=0, wen=0, never asserting cmd_enable.
REQ-010 In CMD, cmd_enable=1, read=load, write=store, other cmd fields from registers; all cmd outputs SHALL be 0 outside CMD.
REQ-011 In CMD, cycle with memtop_i_ready=1 SHALL capture wbck_wdata and wbck_err and go to WBCK; otherwise stay in CMD holding outputs stable.
REQ-012 In WBCK, agu_o_wbck_valid=1; wen = load & ~err; wdata = captured load data for loads, 0 for stores; outputs held stable until agu_i_wbck_ready=1, then go to IDLE.
REQ-013 Minimum latency: accept at edge N, CMD in cycle N+1, wbck_valid in cycle N+2 when memtop_i_ready=1 in N+1; new request accepted no earlier than the cycle after wbck handshake.
REQ-014 Outside WBCK, wbck_valid, wen, err SHALL be 0.

Reset
REQ-015 rst_n low SHALL asynchronously force IDLE and clear all registers; all outputs 0 except agu_o_ready=1.
REQ-016 Reset in CMD or WBCK SHALL abort the operation immediately: cmd_enable and wbck_valid drop without waiting for clk; no writeback is produced after release.

Verification
REQ-017 Load word: rs1=0x1000, imm=0x4, size 10, memtop ready next cycle returning 0xDEADBEEF -> cmd_addr=0x1004, read=1, wmask=0000; wbck wen=1, wdata=0xDEADBEEF, err=0.
REQ-018 Store byte: rs1=0x2000, imm=0x3, rs2=0x000000A5 -> addr=0x2003, wmask=1000, wdata=0xA5A5A5A5, write=1; wbck wen=0.
REQ-019 Misaligned half: rs1=0x11, imm=0, size 01 -> cmd_enable never 1; next cycle wbck_valid=1, err=1, wen=0.
REQ-020 Backpressure: memtop_i_ready low 3 cycles then high; agu_i_wbck_ready low 2 cycles -> cmd outputs and wbck outputs stable throughout; agu_o_ready=0 until handshake completes.
REQ-021 Wrap and error: rs1=0xFFFFFFFC, imm=0x8, load word, memtop_i_wbck_err=1 -> addr=0x00000004; wbck err=1, wen=0.
REQ-022 Reset mid-CMD: assert rst_n low while cmd_enable=1 -> cmd_enable 0 without clk edge; after release agu_o_ready=1, no wbck_valid.
